// File: rtl/intc_pkg.sv
// Shared types and helpers for the intc interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    MASK    = 2'd0,
    PENDING = 2'd1,
    VECTOR  = 2'd2,
    EOI     = 2'd3
  } intc_reg_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intc_state_e;

  // Index of the lowest set bit (highest priority); 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] id;
    id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) id = 5'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// Per-line synchroniser with rising-edge detector; a line already high at reset
// release is absorbed until the chain and the history flop hold real samples.
module intc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic [SYNC_STAGES:0]   arm_r;

  // Synchroniser chain, edge history and post-reset arming shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      arm_r  <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
      arm_r  <= {arm_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r & arm_r[SYNC_STAGES];

endmodule

// File: rtl/intc.sv
// Prioritised edge-triggered interrupt controller (line 0 highest priority).
// Define INTC_NESTING_EN to let a higher-priority line preempt one in service.
module intc
  import intc_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               hwint,
  input  logic               int_ack,
  input  logic [1:0]         reg_sel,
  input  logic               reg_rd,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  localparam logic [NUM_IRQ-1:0] LSB = NUM_IRQ'(32'd1);

  logic [NUM_IRQ-1:0] rise_s, mask_r, pending_r, isr_r;
  logic [NUM_IRQ-1:0] eligible_s, req_oh_s, cur_oh_s, w1c_s;
  logic [NUM_IRQ-1:0] isr_nxt_s, pending_nxt_s;
  logic [4:0]         req_id_s, cur_id_s;
  logic               req_cond_s, ack_s, eoi_s, wr_mask_s;
  intc_state_e        state_r;
  logic               hwint_r;
  logic               unused_s;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq[i]),
      .rise (rise_s[i])
    );
  end

  assign eligible_s = pending_r & mask_r;
  assign req_id_s   = lowest_set(32'(eligible_s));
  assign cur_id_s   = lowest_set(32'(isr_r));
  // x & -x isolates the lowest set bit, giving the one-hot of the winning line.
  assign req_oh_s   = eligible_s & (~eligible_s + LSB);
  assign cur_oh_s   = isr_r & (~isr_r + LSB);

`ifdef INTC_NESTING_EN
  assign req_cond_s = (eligible_s != '0) && ((isr_r == '0) || (req_id_s < cur_id_s));
`else
  assign req_cond_s = (eligible_s != '0) && (isr_r == '0);
`endif

  assign ack_s     = (state_r == REQ) && int_ack && req_cond_s;
  assign eoi_s     = reg_wr && (reg_sel == EOI) && (isr_r != '0);
  assign wr_mask_s = reg_wr && (reg_sel == MASK);
  assign w1c_s     = (reg_wr && (reg_sel == PENDING)) ? reg_wdata[NUM_IRQ-1:0] : '0;
  assign unused_s  = ^reg_wdata;

  // Next in-service and pending state: EOI retires before ack, edge beats W1C.
  always_comb begin
    isr_nxt_s     = isr_r;
    pending_nxt_s = pending_r & ~w1c_s;
    if (eoi_s) isr_nxt_s = isr_nxt_s & ~cur_oh_s;
    else       isr_nxt_s = isr_nxt_s;
    if (ack_s) begin
      isr_nxt_s     = isr_nxt_s | req_oh_s;
      pending_nxt_s = pending_nxt_s & ~req_oh_s;
    end else begin
      isr_nxt_s     = isr_nxt_s;
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s = pending_nxt_s | rise_s;
  end

  // Mask, pending and in-service registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r    <= '0;
      pending_r <= '0;
      isr_r     <= '0;
    end else begin
      mask_r    <= wr_mask_s ? reg_wdata[NUM_IRQ-1:0] : mask_r;
      pending_r <= pending_nxt_s;
      isr_r     <= isr_nxt_s;
    end
  end

  // Request FSM with registered hwint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hwint_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= req_cond_s ? REQ : IDLE;
          hwint_r <= req_cond_s;
        end
        REQ: begin
          if (ack_s || !req_cond_s) begin
            state_r <= IDLE;
            hwint_r <= 1'b0;
          end else begin
            state_r <= REQ;
            hwint_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          hwint_r <= 1'b0;
        end
      endcase
    end
  end

  assign hwint = hwint_r;

  // Register read mux; reads return 0 without a strobe.
  always_comb begin
    reg_rdata = 32'd0;
    if (reg_rd) begin
      case (intc_reg_e'(reg_sel))
        MASK:    reg_rdata = 32'(mask_r);
        PENDING: reg_rdata = 32'(pending_r);
        VECTOR:  reg_rdata = (isr_r != '0) ? {1'b1, 26'd0, cur_id_s} : 32'd0;
        EOI:     reg_rdata = 32'd0;
        default: reg_rdata = 32'd0;
      endcase
    end else begin
      reg_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed table, corner sequences, randomized service order.
module tb_intc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq = 8'h00;
  logic        hwint;
  logic        int_ack = 1'b0;
  logic [1:0]  reg_sel = 2'd0;
  logic        reg_rd = 1'b0;
  logic        reg_wr = 1'b0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] R_MASK = 2'd0, R_PEND = 2'd1, R_VEC = 2'd2, R_EOI = 2'd3;

  typedef struct {
    logic [31:0] mask;
    logic [7:0]  bits;
    logic [31:0] pend;
    logic        hw;
    logic [31:0] vec;
    logic [31:0] pend_after;
  } vec_t;

  vec_t tbl[6];

  intc #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .hwint    (hwint),
    .int_ack  (int_ack),
    .reg_sel  (reg_sel),
    .reg_rd   (reg_rd),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    reg_sel = sel; reg_wdata = data; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0; reg_wdata = 32'd0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] sel, input logic [31:0] exp);
    logic [31:0] v;
    reg_sel = sel; reg_rd = 1'b1;
    #1;
    v = reg_rdata;
    reg_rd = 1'b0;
    check(name, v, exp);
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq = bits;
    tick();
    irq = 8'h00;
  endtask

  task automatic wait_hw(input string name, input logic exp, input int budget);
    int n = 0;
    while (hwint !== exp && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, hwint}, {31'd0, exp});
  endtask

  task automatic cleanup();
    irq = 8'h00;
    wr(R_MASK, 32'd0);
    wr(R_PEND, 32'hFFFF_FFFF);
    repeat (8) wr(R_EOI, 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] m, b;
    int q[$];

    tbl[0] = '{32'h01, 8'h01, 32'h01, 1'b1, 32'h8000_0000, 32'h00};
    tbl[1] = '{32'hFF, 8'h24, 32'h24, 1'b1, 32'h8000_0002, 32'h20};
    tbl[2] = '{32'h00, 8'h08, 32'h08, 1'b0, 32'h0,         32'h08};
    tbl[3] = '{32'hF0, 8'h0F, 32'h0F, 1'b0, 32'h0,         32'h0F};
    tbl[4] = '{32'h80, 8'hC0, 32'hC0, 1'b1, 32'h8000_0007, 32'h40};
    tbl[5] = '{32'h0C, 8'hFF, 32'hFF, 1'b1, 32'h8000_0002, 32'hFB};

    // Reset state
    repeat (3) tick();
    check("rst_hwint", {31'd0, hwint}, 32'd0);
    rd_check("rst_mask", R_MASK, 32'd0);
    rd_check("rst_pend", R_PEND, 32'd0);
    rd_check("rst_vec", R_VEC, 32'd0);
    check("rst_rdata_idle", reg_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Exact latency: edge -> pending after 3 clocks, hwint after 4
    wr(R_MASK, 32'h01);
    rd_check("mask_rb", R_MASK, 32'h01);
    pulse(8'h01);
    tick();
    rd_check("lat_pend_early", R_PEND, 32'h00);
    tick();
    rd_check("lat_pend", R_PEND, 32'h01);
    check("lat_hw_early", {31'd0, hwint}, 32'd0);
    tick();
    check("lat_hw", {31'd0, hwint}, 32'd1);
    ack();
    check("ack_hw_low", {31'd0, hwint}, 32'd0);
    rd_check("ack_vec", R_VEC, 32'h8000_0000);
    rd_check("ack_pend", R_PEND, 32'h00);
    wr(R_EOI, 32'd0);
    rd_check("eoi_vec", R_VEC, 32'd0);
    rd_check("eoi_read0", R_EOI, 32'd0);

    // Table-driven vectors
    for (int k = 0; k < 6; k++) begin
      cleanup();
      wr(R_MASK, tbl[k].mask);
      pulse(tbl[k].bits);
      repeat (4) tick();
      rd_check($sformatf("tbl%0d_pend", k), R_PEND, tbl[k].pend);
      check($sformatf("tbl%0d_hw", k), {31'd0, hwint}, {31'd0, tbl[k].hw});
      if (tbl[k].hw) begin
        ack();
        rd_check($sformatf("tbl%0d_vec", k), R_VEC, tbl[k].vec);
        rd_check($sformatf("tbl%0d_pend_after", k), R_PEND, tbl[k].pend_after);
        check($sformatf("tbl%0d_hw_after", k), {31'd0, hwint}, 32'd0);
      end
    end

    // Two simultaneous edges: 2 first, EOI re-asserts exactly one cycle later
    cleanup();
    wr(R_MASK, 32'hFF);
    pulse(8'h24);
    wait_hw("pri_hw", 1'b1, 8);
    ack();
    rd_check("pri_vec2", R_VEC, 32'h8000_0002);
    rd_check("pri_pend", R_PEND, 32'h20);
    wr(R_EOI, 32'd0);
    check("pri_hw_at_eoi", {31'd0, hwint}, 32'd0);
    tick();
    check("pri_hw_reassert", {31'd0, hwint}, 32'd1);
    ack();
    rd_check("pri_vec5", R_VEC, 32'h8000_0005);
    wr(R_EOI, 32'd0);
    rd_check("pri_vec_end", R_VEC, 32'd0);

    // Masked pending, ack while idle, late unmask, W1C withdraws request
    cleanup();
    pulse(8'h08);
    repeat (5) tick();
    rd_check("msk_pend", R_PEND, 32'h08);
    check("msk_hw", {31'd0, hwint}, 32'd0);
    ack();
    rd_check("idle_ack_pend", R_PEND, 32'h08);
    rd_check("idle_ack_vec", R_VEC, 32'd0);
    wr(R_MASK, 32'h08);
    check("unmask_hw_early", {31'd0, hwint}, 32'd0);
    tick();
    check("unmask_hw", {31'd0, hwint}, 32'd1);
    wr(R_PEND, 32'h08);
    check("w1c_hw_hold", {31'd0, hwint}, 32'd1);
    tick();
    check("w1c_hw_drop", {31'd0, hwint}, 32'd0);
    rd_check("w1c_pend", R_PEND, 32'd0);
    ack();
    rd_check("w1c_idle_ack_vec", R_VEC, 32'd0);

    // Edge and W1C of the same bit in the same cycle: set wins
    cleanup();
    pulse(8'h40);
    tick();
    wr(R_PEND, 32'h40);
    rd_check("w1c_vs_edge", R_PEND, 32'h40);

    // Higher-priority edge while line 4 is in service
    cleanup();
    wr(R_MASK, 32'hFF);
    pulse(8'h10);
    wait_hw("nest_hw4", 1'b1, 8);
    ack();
    rd_check("nest_vec4", R_VEC, 32'h8000_0004);
    pulse(8'h02);
`ifdef INTC_NESTING_EN
    wait_hw("nest_hw1", 1'b1, 8);
    ack();
    rd_check("nest_vec1", R_VEC, 32'h8000_0001);
    wr(R_EOI, 32'd0);
    rd_check("nest_vec_back4", R_VEC, 32'h8000_0004);
    wr(R_EOI, 32'd0);
    rd_check("nest_vec_end", R_VEC, 32'd0);
`else
    repeat (6) tick();
    check("nonest_hw", {31'd0, hwint}, 32'd0);
    rd_check("nonest_pend", R_PEND, 32'h02);
    wr(R_EOI, 32'd0);
    wait_hw("nonest_hw1", 1'b1, 4);
    ack();
    rd_check("nonest_vec1", R_VEC, 32'h8000_0001);
    wr(R_EOI, 32'd0);
    rd_check("nonest_vec_end", R_VEC, 32'd0);
`endif

    // Asynchronous reset mid-service; line held high through release
    cleanup();
    wr(R_MASK, 32'hFF);
    pulse(8'h10);
    wait_hw("rs_hw", 1'b1, 8);
    ack();
    pulse(8'h01);
    repeat (5) tick();
    irq = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async_hw", {31'd0, hwint}, 32'd0);
    rd_check("rs_async_mask", R_MASK, 32'd0);
    rd_check("rs_async_pend", R_PEND, 32'd0);
    rd_check("rs_async_vec", R_VEC, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wr(R_MASK, 32'hFF);
    repeat (8) tick();
    rd_check("rs_held_pend", R_PEND, 32'd0);
    check("rs_held_hw", {31'd0, hwint}, 32'd0);
    irq = 8'h00;
    repeat (4) tick();
    pulse(8'h01);
    wait_hw("rs_new_edge_hw", 1'b1, 8);

    // Randomized: every masked-in line is serviced once, in ascending index order
    for (int it = 0; it < 30; it++) begin
      cleanup();
      m = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      wr(R_MASK, {24'd0, m});
      pulse(b);
      repeat (4) tick();
      rd_check($sformatf("rnd%0d_pend", it), R_PEND, {24'd0, b});
      check($sformatf("rnd%0d_hw", it), {31'd0, hwint}, {31'd0, ((b & m) != 8'd0)});
      q.delete();
      for (int i = 0; i < 8; i++) begin
        if (b[i] && m[i]) q.push_back(i);
      end
      while (q.size() > 0) begin
        int id;
        id = q.pop_front();
        wait_hw($sformatf("rnd%0d_hw_id%0d", it, id), 1'b1, 6);
        ack();
        rd_check($sformatf("rnd%0d_vec", it), R_VEC, 32'h8000_0000 | 32'(id));
        wr(R_EOI, 32'd0);
      end
      repeat (3) tick();
      check($sformatf("rnd%0d_hw_end", it), {31'd0, hwint}, 32'd0);
      rd_check($sformatf("rnd%0d_pend_end", it), R_PEND, {24'd0, b & ~m});
      rd_check($sformatf("rnd%0d_vec_end", it), R_VEC, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
